// File: rtl/operand_collect_stage.sv
// Read-operand stage: holds one issue bundle, resolves operands from bypass or RF,
// and issues the longest ready in-order prefix, keeping blocked lanes in place.
module operand_collect_stage #(
  parameter int LANES     = 2,
  parameter int FWD_SRCS  = 6,
  parameter int PAYLOAD_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ex_stall,
  output logic                       ro_stall,
  input  logic [LANES-1:0]           in_valid,
  input  logic [5*LANES-1:0]         in_src1,
  input  logic [5*LANES-1:0]         in_src2,
  input  logic [LANES-1:0]           in_src2_is_imm,
  input  logic [32*LANES-1:0]        in_imm,
  input  logic [5*LANES-1:0]         in_dest,
  input  logic [PAYLOAD_W*LANES-1:0] in_payload,
  output logic [10*LANES-1:0]        rf_addr,
  input  logic [64*LANES-1:0]        rf_data,
  input  logic [FWD_SRCS-1:0]        fwd_valid,
  input  logic [FWD_SRCS-1:0]        fwd_forwardable,
  input  logic [5*FWD_SRCS-1:0]      fwd_dest,
  input  logic [32*FWD_SRCS-1:0]     fwd_result,
  output logic [LANES-1:0]           out_valid,
  output logic [32*LANES-1:0]        out_src1,
  output logic [32*LANES-1:0]        out_src2,
  output logic [32*LANES-1:0]        out_st_data,
  output logic [5*LANES-1:0]         out_dest,
  output logic [PAYLOAD_W*LANES-1:0] out_payload
);

  logic [LANES-1:0]                held_valid_q, held_valid_d;
  logic [LANES-1:0][4:0]           src1_q, src1_d;
  logic [LANES-1:0][4:0]           src2_q, src2_d;
  logic [LANES-1:0][4:0]           dest_q, dest_d;
  logic [LANES-1:0]                is_imm_q, is_imm_d;
  logic [LANES-1:0][31:0]          imm_q, imm_d;
  logic [LANES-1:0][PAYLOAD_W-1:0] payload_q, payload_d;

  logic [LANES-1:0][32:0] src1_res;
  logic [LANES-1:0][32:0] src2_res;
  logic [LANES-1:0]       lane_ready;
  logic [LANES-1:0]       in_group;

  // Returns {ready, value}; the lowest-index matching bypass source wins.
  function automatic logic [32:0] resolve(
    input logic [4:0]              r,
    input logic [31:0]             rf_val,
    input logic [FWD_SRCS-1:0]     fv,
    input logic [FWD_SRCS-1:0]     ff,
    input logic [5*FWD_SRCS-1:0]   fd,
    input logic [32*FWD_SRCS-1:0]  fr
  );
    logic        found;
    logic [32:0] res;
    found = 1'b0;
    res   = {1'b1, rf_val};
    if (r == 5'd0) begin
      res = {1'b1, 32'd0};
    end else begin
      for (int k = 0; k < FWD_SRCS; k++) begin
        if (!found && fv[k] && fd[5*k +: 5] == r) begin
          found = 1'b1;
          res   = ff[k] ? {1'b1, fr[32*k +: 32]} : {1'b0, 32'd0};
        end
      end
    end
    return res;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign rf_addr[10*gi +: 10] = {src2_q[gi], src1_q[gi]};
      assign src1_res[gi] = resolve(src1_q[gi], rf_data[64*gi +: 32],
                                    fwd_valid, fwd_forwardable, fwd_dest, fwd_result);
      assign src2_res[gi] = resolve(src2_q[gi], rf_data[64*gi+32 +: 32],
                                    fwd_valid, fwd_forwardable, fwd_dest, fwd_result);
      // Readiness ignores the immediate select: store data still needs src2.
      assign lane_ready[gi] = src1_res[gi][32] & src2_res[gi][32];
      assign out_src1[32*gi +: 32]    = src1_res[gi][31:0];
      assign out_src2[32*gi +: 32]    = is_imm_q[gi] ? imm_q[gi] : src2_res[gi][31:0];
      assign out_st_data[32*gi +: 32] = src2_res[gi][31:0];
      assign out_dest[5*gi +: 5]      = dest_q[gi];
      assign out_payload[PAYLOAD_W*gi +: PAYLOAD_W] = payload_q[gi];
    end
  endgenerate

  // Prefix issue: a valid lane that cannot go blocks all younger lanes; holes do not.
  always_comb begin
    logic blocked;
    logic hazard;
    in_group = '0;
    blocked  = 1'b0;
    hazard   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      hazard = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (held_valid_q[j] && dest_q[j] != 5'd0 &&
            (dest_q[j] == src1_q[i] || (!is_imm_q[i] && dest_q[j] == src2_q[i])))
          hazard = 1'b1;
      end
      if (held_valid_q[i] && lane_ready[i] && !blocked && !hazard)
        in_group[i] = 1'b1;
      else if (held_valid_q[i])
        blocked = 1'b1;
    end
  end

  assign out_valid = in_group;
  assign ro_stall  = (|held_valid_q) && (ex_stall || (|(held_valid_q & ~in_group)));

  always_comb begin
    held_valid_d = held_valid_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    dest_d       = dest_q;
    is_imm_d     = is_imm_q;
    imm_d        = imm_q;
    payload_d    = payload_q;
    if (flush) begin
      held_valid_d = '0;
    end else if (!ro_stall) begin
      held_valid_d = in_valid;
      is_imm_d     = in_src2_is_imm;
      for (int i = 0; i < LANES; i++) begin
        src1_d[i]    = in_src1[5*i +: 5];
        src2_d[i]    = in_src2[5*i +: 5];
        dest_d[i]    = in_dest[5*i +: 5];
        imm_d[i]     = in_imm[32*i +: 32];
        payload_d[i] = in_payload[PAYLOAD_W*i +: PAYLOAD_W];
      end
    end else if (!ex_stall) begin
      held_valid_d = held_valid_q & ~in_group;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_valid_q <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      dest_q       <= '0;
      is_imm_q     <= '0;
      imm_q        <= '0;
      payload_q    <= '0;
    end else begin
      held_valid_q <= held_valid_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      dest_q       <= dest_d;
      is_imm_q     <= is_imm_d;
      imm_q        <= imm_d;
      payload_q    <= payload_d;
    end
  end

endmodule

// File: tb/tb_operand_collect_stage.sv
// Directed bench for operand_collect_stage: one task per scenario, inline checks.
module tb_operand_collect_stage;
  localparam int LANES = 2;
  localparam int FWD   = 6;
  localparam int PW    = 64;

  logic                  clk;
  logic                  reset, flush, ex_stall, ro_stall;
  logic [LANES-1:0]      in_valid, in_src2_is_imm, out_valid;
  logic [5*LANES-1:0]    in_src1, in_src2, in_dest, out_dest;
  logic [32*LANES-1:0]   in_imm, out_src1, out_src2, out_st_data;
  logic [PW*LANES-1:0]   in_payload, out_payload;
  logic [10*LANES-1:0]   rf_addr;
  logic [64*LANES-1:0]   rf_data;
  logic [FWD-1:0]        fwd_valid, fwd_forwardable;
  logic [5*FWD-1:0]      fwd_dest;
  logic [32*FWD-1:0]     fwd_result;

  logic [31:0] rf_mem [32];
  int errors = 0;
  int checks = 0;

  operand_collect_stage #(.LANES(LANES), .FWD_SRCS(FWD), .PAYLOAD_W(PW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ex_stall(ex_stall), .ro_stall(ro_stall),
    .in_valid(in_valid), .in_src1(in_src1), .in_src2(in_src2),
    .in_src2_is_imm(in_src2_is_imm), .in_imm(in_imm), .in_dest(in_dest),
    .in_payload(in_payload), .rf_addr(rf_addr), .rf_data(rf_data),
    .fwd_valid(fwd_valid), .fwd_forwardable(fwd_forwardable), .fwd_dest(fwd_dest),
    .fwd_result(fwd_result), .out_valid(out_valid), .out_src1(out_src1),
    .out_src2(out_src2), .out_st_data(out_st_data), .out_dest(out_dest),
    .out_payload(out_payload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read at the addresses the stage presents.
  always_comb begin
    rf_data = '0;
    for (int l = 0; l < 2*LANES; l++) rf_data[32*l +: 32] = rf_mem[rf_addr[5*l +: 5]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic set_lane(input int i, input logic [4:0] s1, input logic [4:0] s2,
                          input logic isimm, input logic [31:0] imm,
                          input logic [4:0] d, input logic [63:0] pl);
    in_src1[5*i +: 5]     = s1;
    in_src2[5*i +: 5]     = s2;
    in_src2_is_imm[i]     = isimm;
    in_imm[32*i +: 32]    = imm;
    in_dest[5*i +: 5]     = d;
    in_payload[PW*i +: PW] = pl;
  endtask

  task automatic set_fwd(input int k, input logic v, input logic f,
                         input logic [4:0] d, input logic [31:0] r);
    fwd_valid[k]          = v;
    fwd_forwardable[k]    = f;
    fwd_dest[5*k +: 5]    = d;
    fwd_result[32*k +: 32] = r;
  endtask

  task automatic clear_fwd();
    fwd_valid = '0; fwd_forwardable = '0; fwd_dest = '0; fwd_result = '0;
  endtask

  // Presents a bundle for one cycle; returns #1 after the load edge.
  task automatic load_bundle(input logic [LANES-1:0] v);
    @(posedge clk); #1;
    in_valid = v;
    @(posedge clk); #1;
    in_valid = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; ex_stall = 1'b0; in_valid = '0;
    in_src1 = '0; in_src2 = '0; in_src2_is_imm = '0; in_imm = '0; in_dest = '0;
    in_payload = '0; clear_fwd();
    for (int r = 0; r < 32; r++) rf_mem[r] = 32'h1000 + r;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid got=%b exp=00", out_valid); end
    checks++; if (ro_stall !== 1'b0) begin errors++; $display("FAIL reset_ro_stall got=%b exp=0", ro_stall); end
    checks++; if (rf_addr !== '0 || out_dest !== '0 || out_payload !== '0) begin errors++; $display("FAIL reset_fields rf_addr=%h dest=%h payload=%h exp=0", rf_addr, out_dest, out_payload); end
    checks++; if (out_src1 !== '0 || out_src2 !== '0 || out_st_data !== '0) begin errors++; $display("FAIL reset_operands src1=%h src2=%h st=%h exp=0", out_src1, out_src2, out_st_data); end
    reset = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_independent();
    rf_mem[2] = 32'd5; rf_mem[3] = 32'd7; rf_mem[4] = 32'd9; rf_mem[8] = 32'h88;
    set_lane(0, 5'd2, 5'd3, 1'b0, 32'h0, 5'd6, 64'hAAAA);
    set_lane(1, 5'd4, 5'd8, 1'b1, 32'h10, 5'd7, 64'hBBBB);
    load_bundle(2'b11);
    checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL indep_valid got=%b exp=11", out_valid); end
    checks++; if (out_src1 !== {32'd9, 32'd5}) begin errors++; $display("FAIL indep_src1 got=%h exp=%h", out_src1, {32'd9, 32'd5}); end
    checks++; if (out_src2 !== {32'h10, 32'd7}) begin errors++; $display("FAIL indep_src2 got=%h exp=%h", out_src2, {32'h10, 32'd7}); end
    checks++; if (out_st_data !== {32'h88, 32'd7}) begin errors++; $display("FAIL indep_st_data got=%h exp=%h", out_st_data, {32'h88, 32'd7}); end
    checks++; if (ro_stall !== 1'b0) begin errors++; $display("FAIL indep_ro_stall got=%b exp=0", ro_stall); end
    checks++; if (rf_addr !== {5'd8, 5'd4, 5'd3, 5'd2}) begin errors++; $display("FAIL indep_rf_addr got=%h exp=%h", rf_addr, {5'd8, 5'd4, 5'd3, 5'd2}); end
    checks++; if (out_dest !== {5'd7, 5'd6} || out_payload !== {64'hBBBB, 64'hAAAA}) begin errors++; $display("FAIL indep_passthru dest=%h payload=%h", out_dest, out_payload); end
    $display("test_independent: done");
  endtask

  task automatic test_bypass();
    rf_mem[4] = 32'h99;
    set_lane(0, 5'd4, 5'd0, 1'b0, 32'h0, 5'd0, 64'h1);
    set_lane(1, 5'd0, 5'd0, 1'b0, 32'h0, 5'd0, 64'h2);
    set_fwd(0, 1'b1, 1'b1, 5'd4, 32'h11);
    set_fwd(2, 1'b1, 1'b1, 5'd4, 32'h22);
    load_bundle(2'b01);
    checks++; if (out_valid !== 2'b01) begin errors++; $display("FAIL bypass_valid got=%b exp=01", out_valid); end
    checks++; if (out_src1[31:0] !== 32'h11) begin errors++; $display("FAIL bypass_fwd0 got=%h exp=11", out_src1[31:0]); end
    fwd_valid[0] = 1'b0; #1;
    checks++; if (out_src1[31:0] !== 32'h22) begin errors++; $display("FAIL bypass_fwd2 got=%h exp=22", out_src1[31:0]); end
    fwd_valid[2] = 1'b0; #1;
    checks++; if (out_src1[31:0] !== 32'h99) begin errors++; $display("FAIL bypass_rf got=%h exp=99", out_src1[31:0]); end
    clear_fwd();
    $display("test_bypass: done");
  endtask

  task automatic test_load_use();
    set_fwd(0, 1'b1, 1'b0, 5'd4, 32'hDEAD);
    set_lane(0, 5'd4, 5'd0, 1'b0, 32'h0, 5'd0, 64'h3);
    load_bundle(2'b01);
    checks++; if (out_valid !== 2'b00 || ro_stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall valid=%b ro_stall=%b exp=00/1", out_valid, ro_stall); end
    @(posedge clk); #1;
    fwd_forwardable[0] = 1'b1; fwd_result[31:0] = 32'h33; #1;
    checks++; if (out_valid !== 2'b01 || ro_stall !== 1'b0) begin errors++; $display("FAIL loaduse_release valid=%b ro_stall=%b exp=01/0", out_valid, ro_stall); end
    checks++; if (out_src1[31:0] !== 32'h33) begin errors++; $display("FAIL loaduse_value got=%h exp=33", out_src1[31:0]); end
    clear_fwd();
    $display("test_load_use: done");
  endtask

  task automatic test_raw_split();
    rf_mem[1] = 32'h1; rf_mem[2] = 32'h2; rf_mem[3] = 32'h3; rf_mem[5] = 32'h55;
    set_lane(0, 5'd1, 5'd2, 1'b0, 32'h0, 5'd5, 64'hC0);
    set_lane(1, 5'd5, 5'd3, 1'b0, 32'h0, 5'd6, 64'hC1);
    load_bundle(2'b11);
    checks++; if (out_valid !== 2'b01 || ro_stall !== 1'b1) begin errors++; $display("FAIL raw_cycle1 valid=%b ro_stall=%b exp=01/1", out_valid, ro_stall); end
    @(posedge clk); #1;
    set_fwd(0, 1'b1, 1'b1, 5'd5, 32'h44); #1;
    checks++; if (out_valid !== 2'b10 || ro_stall !== 1'b0) begin errors++; $display("FAIL raw_cycle2 valid=%b ro_stall=%b exp=10/0", out_valid, ro_stall); end
    checks++; if (out_src1[63:32] !== 32'h44 || out_payload[127:64] !== 64'hC1) begin errors++; $display("FAIL raw_lane1 src1=%h payload=%h exp=44/C1", out_src1[63:32], out_payload[127:64]); end
    clear_fwd();
    // An invalid older lane must neither block nor create a hazard.
    load_bundle(2'b10);
    checks++; if (out_valid !== 2'b10 || ro_stall !== 1'b0) begin errors++; $display("FAIL hole_skip valid=%b ro_stall=%b exp=10/0", out_valid, ro_stall); end
    $display("test_raw_split: done");
  endtask

  task automatic test_stall_hold();
    set_fwd(0, 1'b1, 1'b1, 5'd0, 32'hFF);
    set_lane(0, 5'd0, 5'd0, 1'b0, 32'h0, 5'd0, 64'hD0);
    set_lane(1, 5'd0, 5'd0, 1'b0, 32'h0, 5'd0, 64'hD1);
    load_bundle(2'b01);
    checks++; if (out_src1[31:0] !== 32'h0 || out_valid !== 2'b01) begin errors++; $display("FAIL zero_reg src1=%h valid=%b exp=0/01", out_src1[31:0], out_valid); end
    ex_stall = 1'b1;
    set_lane(0, 5'd2, 5'd3, 1'b0, 32'h0, 5'd0, 64'hE0);
    set_lane(1, 5'd4, 5'd0, 1'b1, 32'h20, 5'd0, 64'hE1);
    in_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 2'b01 || ro_stall !== 1'b1 || out_payload[63:0] !== 64'hD0) begin errors++; $display("FAIL stall_hold cyc=%0d valid=%b ro_stall=%b payload=%h exp=01/1/D0", c, out_valid, ro_stall, out_payload[63:0]); end
    end
    ex_stall = 1'b0;
    @(posedge clk); #1;
    in_valid = '0;
    checks++; if (out_valid !== 2'b11 || out_payload[63:0] !== 64'hE0 || out_src2[63:32] !== 32'h20) begin errors++; $display("FAIL stall_reload valid=%b payload=%h src2=%h exp=11/E0/20", out_valid, out_payload[63:0], out_src2[63:32]); end
    clear_fwd();
    $display("test_stall_hold: done");
  endtask

  task automatic test_flush();
    set_fwd(0, 1'b1, 1'b0, 5'd4, 32'h0);
    set_lane(0, 5'd4, 5'd0, 1'b0, 32'h0, 5'd0, 64'hF0);
    set_lane(1, 5'd0, 5'd0, 1'b0, 32'h0, 5'd0, 64'h0);
    load_bundle(2'b01);
    checks++; if (ro_stall !== 1'b1 || out_valid !== 2'b00) begin errors++; $display("FAIL flush_pre ro_stall=%b valid=%b exp=1/00", ro_stall, out_valid); end
    flush = 1'b1; ex_stall = 1'b1;
    set_lane(0, 5'd2, 5'd3, 1'b0, 32'h0, 5'd0, 64'hF9);
    in_valid = 2'b11;
    @(posedge clk); #1;
    flush = 1'b0; ex_stall = 1'b0; in_valid = '0;
    checks++; if (out_valid !== 2'b00 || ro_stall !== 1'b0) begin errors++; $display("FAIL flush_empty valid=%b ro_stall=%b exp=00/0", out_valid, ro_stall); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL flush_dropped valid=%b exp=00", out_valid); end
    set_lane(0, 5'd4, 5'd0, 1'b0, 32'h0, 5'd9, 64'hF1);
    load_bundle(2'b01);
    checks++; if (ro_stall !== 1'b1) begin errors++; $display("FAIL reset_pre ro_stall=%b exp=1", ro_stall); end
    reset = 1'b1; ex_stall = 1'b1; in_valid = 2'b11;
    @(posedge clk); #1;
    reset = 1'b0; ex_stall = 1'b0; in_valid = '0;
    checks++; if (out_valid !== 2'b00 || ro_stall !== 1'b0) begin errors++; $display("FAIL reset_mid valid=%b ro_stall=%b exp=00/0", out_valid, ro_stall); end
    checks++; if (out_payload !== '0 || out_dest !== '0 || rf_addr !== '0) begin errors++; $display("FAIL reset_mid_fields payload=%h dest=%h rf_addr=%h exp=0", out_payload, out_dest, rf_addr); end
    clear_fwd();
    $display("test_flush: done");
  endtask

  initial begin
    test_reset();
    test_independent();
    test_bypass();
    test_load_use();
    test_raw_split();
    test_stall_hold();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
